// File: rtl/prio_enc_seg_if.sv
// Request/encode/display signal bundle for prio_enc_seg.
// The master drives enable and requests. The slave (the encoder) drives the
// registered index, flags and 7-segment outputs.
interface prio_enc_seg_if #(
  parameter int N = 16
);
  localparam int W      = $clog2(N);
  localparam int DIGITS = (W + 3) / 4;

  logic              en;
  logic [N-1:0]      x;
  logic [W-1:0]      y;
  logic              flag;
  logic              chg;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  modport master (
    output en, x,
    input  y, flag, chg, an, seg
  );

  modport slave (
    input  en, x,
    output y, flag, chg, an, seg
  );
endinterface

// File: rtl/prio_enc_seg.sv
// N-input priority encoder with registered index/valid, optional hold-last,
// change-detect pulse, and an active-low hex 7-segment scanner over all
// index digits.
module prio_enc_seg #(
  parameter int N        = 16,
  parameter int SCAN_DIV = 1000,
  parameter int HOLD     = 0
) (
  input logic           clk,
  input logic           rst,
  prio_enc_seg_if.slave bus
);
  localparam int W      = $clog2(N);
  localparam int DIGITS = (W + 3) / 4;
  localparam int CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [W-1:0]        y_q, y_d;
  logic                flag_q, flag_d;
  logic                chg_q, chg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic [W-1:0]        idx;
  logic                any_set;
  logic                wrap;
  logic [4*DIGITS-1:0] yext;
  logic [3:0]          nib;

  // Active-high {a..g} hex font.
  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'h7E;
      4'h1: f = 7'h30;
      4'h2: f = 7'h6D;
      4'h3: f = 7'h79;
      4'h4: f = 7'h33;
      4'h5: f = 7'h5B;
      4'h6: f = 7'h5F;
      4'h7: f = 7'h70;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h7B;
      4'hA: f = 7'h77;
      4'hB: f = 7'h1F;
      4'hC: f = 7'h4E;
      4'hD: f = 7'h3D;
      4'hE: f = 7'h4F;
      default: f = 7'h47;
    endcase
    return f;
  endfunction

  // Highest-numbered set request bit; later iterations override earlier ones.
  always_comb begin
    idx     = '0;
    any_set = |bus.x;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.x[i]) idx = W'(i);
    end
  end

  // Encoder next state and change detection against the current outputs.
  always_comb begin
    y_d    = y_q;
    flag_d = flag_q;
    if (!bus.en) begin
      y_d    = '0;
      flag_d = 1'b0;
    end else if (any_set) begin
      y_d    = idx;
      flag_d = 1'b1;
    end else begin
      flag_d = 1'b0;
      if (HOLD == 0) y_d = '0;
    end
    chg_d = ({y_d, flag_d} != {y_q, flag_q});
  end

  // Scan timing, digit pointer, and display drive from the current ptr and y.
  always_comb begin
    wrap  = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    ptr_d = ptr_q;
    if (DIGITS > 1 && wrap) begin
      ptr_d = (ptr_q == PW'(DIGITS - 1)) ? '0 : ptr_q + 1'b1;
    end

    yext = (4*DIGITS)'(y_q);
    nib  = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (ptr_q == PW'(d)) nib = yext[4*d +: 4];
    end

    an_d = ~(DIGITS'(1) << ptr_q);
    if (HOLD == 0 && !flag_q) seg_d = '1;
    else                      seg_d = ~font(nib);
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      flag_q <= 1'b0;
      chg_q  <= 1'b0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      an_q   <= ~DIGITS'(1);
      seg_q  <= '1;
    end else begin
      y_q    <= y_d;
      flag_q <= flag_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.flag = flag_q;
  assign bus.chg  = chg_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
endmodule

// File: tb/tb_prio_enc_seg.sv
// Directed bench for prio_enc_seg: two N=16 encoders (HOLD=0 / HOLD=1) and
// one N=256 two-digit encoder, all with SCAN_DIV=4 and a shared clock/reset.
module tb_prio_enc_seg;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  prio_enc_seg_if #(.N(16))  if_a ();
  prio_enc_seg_if #(.N(16))  if_b ();
  prio_enc_seg_if #(.N(256)) if_c ();

  prio_enc_seg #(.N(16),  .SCAN_DIV(4), .HOLD(0)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  prio_enc_seg #(.N(16),  .SCAN_DIV(4), .HOLD(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  prio_enc_seg #(.N(256), .SCAN_DIV(4), .HOLD(0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [255:0] xv;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    if_a.en = 1'b0; if_a.x = '0;
    if_b.en = 1'b0; if_b.x = '0;
    if_c.en = 1'b0; if_c.x = '0;
    xv = '0;
    xv[165] = 1'b1;
    xv[100] = 1'b1;
    xv[3]   = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_y",    if_a.y, 0);
    chk("rst_flag", if_a.flag, 0);
    chk("rst_chg",  if_a.chg, 0);
    chk("rst_seg",  if_a.seg, 7'h7F);
    chk("rst_an1",  if_a.an, 1'b0);
    chk("rst_an2",  if_c.an, 2'b10);
    #9 rst = 1'b0;                      // released at t=12, between edges

    // Test 1: x=8421 -> y=15, flag, chg pulse, then "F"
    if_a.en = 1'b1; if_a.x = 16'h8421;
    tick(1);
    chk("t1_y",    if_a.y, 15);
    chk("t1_flag", if_a.flag, 1);
    chk("t1_chg",  if_a.chg, 1);
    chk("t1_seg0", if_a.seg, 7'h7F);
    tick(1);
    chk("t1_seg",  if_a.seg, 7'h38);
    chk("t1_chg0", if_a.chg, 0);
    chk("t1_an",   if_a.an, 1'b0);

    // Test 2: x=0 clears and blanks, x=1 gives index 0 with flag
    if_a.x = 16'h0000;
    tick(1);
    chk("t2_y",    if_a.y, 0);
    chk("t2_flag", if_a.flag, 0);
    chk("t2_chg",  if_a.chg, 1);
    tick(1);
    chk("t2_blank", if_a.seg, 7'h7F);
    chk("t2_chg0",  if_a.chg, 0);
    if_a.x = 16'h0001;
    tick(1);
    chk("t2_y1",    if_a.y, 0);
    chk("t2_flag1", if_a.flag, 1);
    chk("t2_chg1",  if_a.chg, 1);
    tick(1);
    chk("t2_seg1",  if_a.seg, 7'h01);

    // Test 3: en=0 with all requests set
    if_a.en = 1'b0; if_a.x = 16'hFFFF;
    tick(1);
    chk("t3_y",    if_a.y, 0);
    chk("t3_flag", if_a.flag, 0);
    chk("t3_chg",  if_a.chg, 1);
    tick(1);
    chk("t3_chg0", if_a.chg, 0);
    chk("t3_y0",   if_a.y, 0);
    if_a.en = 1'b1;
    tick(1);
    chk("t3_yen",    if_a.y, 15);
    chk("t3_flagen", if_a.flag, 1);
    chk("t3_chgen",  if_a.chg, 1);

    // Test 4: HOLD=1 keeps index 6 after requests drop
    if_b.en = 1'b1; if_b.x = 16'h0040;
    tick(1);
    chk("t4_y",    if_b.y, 6);
    chk("t4_flag", if_b.flag, 1);
    chk("t4_chg",  if_b.chg, 1);
    if_b.x = 16'h0000;
    tick(1);
    chk("t4_yhold", if_b.y, 6);
    chk("t4_flag0", if_b.flag, 0);
    chk("t4_chg2",  if_b.chg, 1);
    chk("t4_seg",   if_b.seg, 7'h20);
    tick(1);
    chk("t4_chg0",  if_b.chg, 0);
    chk("t4_seg2",  if_b.seg, 7'h20);
    chk("t4_y2",    if_b.y, 6);

    // Test 5: N=256, highest bit 165 = 8'hA5, scan across two digits
    if_c.en = 1'b1; if_c.x = xv;
    rst = 1'b1;
    #1;
    chk("t5_rst_an", if_c.an, 2'b10);
    #3 rst = 1'b0;                      // release between edges
    tick(2);
    chk("t5_y",    if_c.y, 8'hA5);
    chk("t5_flag", if_c.flag, 1);
    chk("t5_an0",  if_c.an, 2'b10);
    chk("t5_seg0", if_c.seg, 7'h24);
    tick(2);
    chk("t5_an0b", if_c.an, 2'b10);
    tick(1);
    chk("t5_an1",  if_c.an, 2'b01);
    chk("t5_seg1", if_c.seg, 7'h08);
    tick(1);                            // edge 6: ptr=1, cnt=2
    chk("t5_an1b", if_c.an, 2'b01);

    // Test 6: async reset mid-scan, no clock edge needed
    #1 rst = 1'b1;
    #1;
    chk("t6_an",   if_c.an, 2'b10);
    chk("t6_seg",  if_c.seg, 7'h7F);
    chk("t6_y",    if_c.y, 0);
    chk("t6_flag", if_c.flag, 0);
    #3 rst = 1'b0;
    tick(1);
    chk("t6_r_an",  if_c.an, 2'b10);
    chk("t6_r_seg", if_c.seg, 7'h7F);
    tick(1);
    chk("t6_r_seg0", if_c.seg, 7'h24);
    tick(3);
    chk("t6_r_an1",  if_c.an, 2'b01);
    chk("t6_r_seg1", if_c.seg, 7'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
